// File: rtl/mem_access_lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-size
// encodings and the byte-enable mask generator.
package mem_access_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Mask is built for the widest bus (8 lanes); narrower buses truncate it.
    function automatic logic [7:0] lsu_be_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] be;
        case (size)
            SZ_B:    be = 8'h01 << off;
            SZ_H:    be = 8'h03 << off;
            SZ_W:    be = 8'h0F << off;
            SZ_D:    be = 8'hFF;
            default: be = 8'h00;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_lsu_load_align.sv
// Load-data lane steering: moves the addressed lane to bit 0 and applies
// sign or zero extension from the access size.
module lsu_load_align
    import mem_access_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  i_rdata,
    input  logic [OFF_W-1:0] i_off,
    input  logic [1:0]       i_size,
    input  logic             i_sign,
    output logic [XLEN-1:0]  o_data
);

    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_fill;
    logic            w_msb;

    assign w_lane = i_rdata >> {i_off, 3'b000};

    // Mask keeps the accessed bits; everything above is filled from the lane MSB or zero.
    always_comb begin
        w_mask = {XLEN{1'b1}};
        w_msb  = 1'b0;
        case (i_size)
            SZ_B: begin
                w_mask = XLEN'(64'h0000_0000_0000_00FF);
                w_msb  = w_lane[7];
            end
            SZ_H: begin
                w_mask = XLEN'(64'h0000_0000_0000_FFFF);
                w_msb  = w_lane[15];
            end
            SZ_W: begin
                w_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
                w_msb  = w_lane[31];
            end
            default: begin
                w_mask = {XLEN{1'b1}};
                w_msb  = 1'b0;
            end
        endcase
    end

    assign w_fill = {XLEN{i_sign & w_msb}};
    assign o_data = (w_lane & w_mask) | (w_fill & ~w_mask);

endmodule

// File: rtl/mem_access_lsu.sv
// Load/store unit between execute and write-back: one operation per handshake,
// variable-latency data-memory port, alignment checks and load extension.
module mem_access_lsu
    import mem_access_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mem_rEn,
    input  logic                mem_wEn,
    input  logic [1:0]          MemSize,
    input  logic                load_extend_sign,
    input  logic [ADDR_W-1:0]   ALU_result,
    input  logic [XLEN-1:0]     Rdata2,
    output logic                out_valid,
    output logic [XLEN-1:0]     out_data,
    output logic                out_misalign,
    output logic                out_fault,
    output logic                stall,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic                dmem_req_we,
    output logic [ADDR_W-1:0]   dmem_req_addr,
    output logic [XLEN/8-1:0]   dmem_req_be,
    output logic [XLEN-1:0]     dmem_req_wdata,
    input  logic                dmem_rsp_valid,
    input  logic [XLEN-1:0]     dmem_rsp_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        r_state;
    logic [15:0]       r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_data;
    logic              r_out_misalign;
    logic              r_out_fault;
    logic              r_req_valid;
    logic              r_req_we;
    logic [ADDR_W-1:0] r_req_addr;
    logic [NB-1:0]     r_req_be;
    logic [XLEN-1:0]   r_req_wdata;
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic              r_sign;

    logic              w_is_mem;
    logic              w_size_ok;
    logic [2:0]        w_align_mask;
    logic              w_misalign;
    logic [OFF_W-1:0]  w_off;
    logic [7:0]        w_be8;
    logic [XLEN-1:0]   w_wdata;
    logic [ADDR_W-1:0] w_addr_al;
    logic [XLEN-1:0]   w_load_data;

    assign w_is_mem  = mem_rEn | mem_wEn;
    assign w_off     = ALU_result[OFF_W-1:0];
    assign w_size_ok = (MemSize != SZ_D) || (XLEN == 64);
    assign w_be8     = lsu_be_mask(MemSize, 3'(w_off));
    assign w_addr_al = {ALU_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Low address bits that must be zero for a naturally aligned access.
    always_comb begin
        w_align_mask = 3'b111;
        case (MemSize)
            SZ_B:    w_align_mask = 3'b000;
            SZ_H:    w_align_mask = 3'b001;
            SZ_W:    w_align_mask = 3'b011;
            SZ_D:    w_align_mask = 3'b111;
            default: w_align_mask = 3'b111;
        endcase
    end

    assign w_misalign = !w_size_ok || ((ALU_result[2:0] & w_align_mask) != 3'b000);

    // Store data replicated across every lane so memory picks it up via byte enables.
    always_comb begin
        w_wdata = Rdata2;
        case (MemSize)
            SZ_B:    w_wdata = {NB{Rdata2[7:0]}};
            SZ_H:    w_wdata = {(XLEN/16){Rdata2[15:0]}};
            SZ_W:    w_wdata = {(XLEN/32){Rdata2[31:0]}};
            default: w_wdata = Rdata2;
        endcase
    end

    lsu_load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .i_rdata (dmem_rsp_rdata),
        .i_off   (r_off),
        .i_size  (r_size),
        .i_sign  (r_sign),
        .o_data  (w_load_data)
    );

    // Control FSM; result fields default to zero so they pulse only with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 16'd0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_misalign <= 1'b0;
            r_out_fault    <= 1'b0;
            r_req_valid    <= 1'b0;
            r_req_we       <= 1'b0;
            r_req_addr     <= '0;
            r_req_be       <= '0;
            r_req_wdata    <= '0;
            r_off          <= '0;
            r_size         <= 2'b00;
            r_sign         <= 1'b0;
        end else begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_misalign <= 1'b0;
            r_out_fault    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_off      <= w_off;
                        r_size     <= MemSize;
                        r_sign     <= load_extend_sign;
                        if (!w_is_mem) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= XLEN'(ALU_result);
                        end else if (w_misalign) begin
                            r_state        <= ST_DONE;
                            r_out_valid    <= 1'b1;
                            r_out_misalign <= 1'b1;
                        end else begin
                            r_state     <= ST_REQ;
                            r_req_valid <= 1'b1;
                            r_req_we    <= mem_wEn & ~mem_rEn;
                            r_req_addr  <= w_addr_al;
                            r_req_be    <= NB'(w_be8);
                            r_req_wdata <= w_wdata;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_req_we    <= 1'b0;
                        r_req_addr  <= '0;
                        r_req_be    <= '0;
                        r_req_wdata <= '0;
                        r_cnt       <= 16'd0;
                        if (r_req_we) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    // A response in the cycle the count reaches TIMEOUT still wins.
                    if (dmem_rsp_valid) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_load_data;
                        r_cnt       <= 16'd0;
                    end else if ((r_cnt + 16'd1) == 16'(TIMEOUT)) begin
                        r_state     <= ST_DRAIN;
                        r_out_valid <= 1'b1;
                        r_out_fault <= 1'b1;
                        r_cnt       <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
                ST_DRAIN: begin
                    if (dmem_rsp_valid) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_req_valid <= 1'b0;
                    r_cnt       <= 16'd0;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign stall          = in_valid & ~r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_misalign   = r_out_misalign;
    assign out_fault      = r_out_fault;
    assign dmem_req_valid = r_req_valid;
    assign dmem_req_we    = r_req_we;
    assign dmem_req_addr  = r_req_addr;
    assign dmem_req_be    = r_req_be;
    assign dmem_req_wdata = r_req_wdata;

endmodule
